key_debounce: RTL and testbench

- Input-side companion to the LED flow/blink timers: it conditions raw board push-buttons (active-low, bouncing, asynchronous) into clean per-key events.
- Per key it provides a debounced level, single-cycle press and release strobes, and optionally a long-press strobe.
- Sits between board key pins and LED/mode control logic.
- All timing is derived from sys_clk cycle counts. The defaults assume a 50 MHz clock.

---
 rtl/key_debounce.sv | 155 +++++++++++++++
 tb/tb_key_debounce.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop sync, per-key debounce FSM, press/release strobes.
// Optional long-press strobe is built when the KEY_LONG_EN macro is defined.
module key_debounce #(
  parameter int KEY_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int CNT_W           = 26
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_value,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("key_debounce: invalid DEBOUNCE_CYCLES/LONG_CYCLES combination");
  end

  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] w_ks;

  // Sync flops reset to the released pin level so a held key must re-qualify.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ks = ~r_sync2;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             r_release;
    logic             w_press_nxt;
    logic             w_release_nxt;
`ifdef KEY_LONG_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
    logic             r_long;
    logic             w_long_nxt;
`endif

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
`ifdef KEY_LONG_EN
      w_long_nxt    = 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_ks[g]) begin
            w_state_nxt = PRESS_CHK;
            w_cnt_nxt   = '0;
          end
        end
        PRESS_CHK: begin
          if (!w_ks[g]) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!w_ks[g]) begin
            w_state_nxt = RELEASE_CHK;
            w_cnt_nxt   = '0;
          end
`ifdef KEY_LONG_EN
          // Parking the count one past the fire point makes key_long once-per-press.
          else if (r_cnt == LONG_LAST) begin
            w_long_nxt = 1'b1;
            w_cnt_nxt  = LONG_SAT;
          end else if (r_cnt < LONG_LAST) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (w_ks[g]) begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
`ifdef KEY_LONG_EN
        r_long    <= 1'b0;
`endif
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
`ifdef KEY_LONG_EN
        r_long    <= w_long_nxt;
`endif
      end
    end

    assign key_value[g]   = (r_state == HELD) || (r_state == RELEASE_CHK);
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
`ifdef KEY_LONG_EN
    assign key_long[g]    = r_long;
`else
    assign key_long[g]    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// Randomized + directed bench for key_debounce, checked every cycle against a
// run-length reference model of the debounce rules.
module tb_key_debounce;

  localparam int KN = 4;
  localparam int D  = 10;
  localparam int L  = 50;
  localparam int CW = 8;
`ifdef KEY_LONG_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [KN-1:0] key_in;
  logic [KN-1:0] key_value;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;
  logic [KN-1:0] key_long;

  always #5 sys_clk = ~sys_clk;

  key_debounce #(
    .KEY_NUM        (KN),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .CNT_W          (CW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model: pin delay line, accepted level, and run lengths.
  logic          pinD1 [KN];
  logic          pinD2 [KN];
  logic          level [KN];
  int            run   [KN];
  int            holdRun [KN];
  bit            goodPrev [KN];
  logic [KN-1:0] expValue;
  logic [KN-1:0] expPress;
  logic [KN-1:0] expRelease;
  logic [KN-1:0] expLong;
  int            pressCount = 0;
  int            longCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A change is accepted once the synchronized sample has disagreed with the
  // accepted level on D+1 consecutive edges; a long press needs L further
  // uninterrupted held edges.
  task automatic stepModel();
    logic s;
    for (int k = 0; k < KN; k++) begin
      expPress[k]   = 1'b0;
      expRelease[k] = 1'b0;
      expLong[k]    = 1'b0;
      if (sys_rst) begin
        pinD1[k]    = 1'b1;
        pinD2[k]    = 1'b1;
        level[k]    = 1'b0;
        run[k]      = 0;
        holdRun[k]  = 0;
        goodPrev[k] = 1'b0;
      end else begin
        s = ~pinD2[k];
        pinD2[k] = pinD1[k];
        pinD1[k] = key_in[k];
        if (s != level[k]) begin
          run[k]++;
          goodPrev[k] = 1'b0;
          if (run[k] == D + 1) begin
            level[k] = s;
            run[k]   = 0;
            if (s) begin
              expPress[k] = 1'b1;
              goodPrev[k] = 1'b1;
              holdRun[k]  = 0;
            end else begin
              expRelease[k] = 1'b1;
            end
          end
        end else begin
          run[k] = 0;
          if (level[k]) begin
            if (goodPrev[k]) begin
              holdRun[k]++;
              if (holdRun[k] == L && LONG_ON) expLong[k] = 1'b1;
            end else begin
              holdRun[k] = 0;
            end
            goodPrev[k] = 1'b1;
          end
        end
      end
      expValue[k] = level[k];
    end
  endtask

  task automatic applyStimulus(input logic [KN-1:0] keys, input logic rstVal);
    key_in  = keys;
    sys_rst = rstVal;
    @(posedge sys_clk);
    stepModel();
    @(negedge sys_clk);
    checkOutput("value",   32'(key_value),   32'(expValue));
    checkOutput("press",   32'(key_press),   32'(expPress));
    checkOutput("release", 32'(key_release), 32'(expRelease));
    checkOutput("long",    32'(key_long),    32'(expLong));
    checkOutput("exclusive", 32'(key_press & key_release), 32'd0);
    pressCount += $countones(expPress);
    longCount  += $countones(expLong);
  endtask

  initial begin
    logic [KN-1:0] keys;
    key_in  = '1;
    sys_rst = 1'b1;

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b1);
    for (int i = 0; i < 100; i++) applyStimulus(4'b1111, 1'b0);

    $display("[TB] clean press on key 0");
    for (int i = 0; i < 40; i++) applyStimulus(4'b1110, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111, 1'b0);

    $display("[TB] bounce on key 1");
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 4; j++) applyStimulus((i % 2 == 0) ? 4'b1101 : 4'b1111, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(4'b1101, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111, 1'b0);

    $display("[TB] long hold on key 2");
    for (int i = 0; i < 200; i++) applyStimulus(4'b1011, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111, 1'b0);

    $display("[TB] simultaneous keys 1 and 3");
    for (int i = 0; i < 30; i++) applyStimulus(4'b0101, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111, 1'b0);

    $display("[TB] reset while key 3 held");
    for (int i = 0; i < 20; i++) applyStimulus(4'b0111, 1'b0);
    applyStimulus(4'b0111, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(4'b0111, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111, 1'b0);

    $display("[TB] randomized bouncing");
    keys = '1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < KN; k++)
        if ($urandom_range(((cyc / 250) % 2 == 1) ? 40 : 3, 1) == 1) keys[k] = ~keys[k];
      applyStimulus(keys, ($urandom_range(600, 1) == 1) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111, 1'b0);

    checkOutput("pressSeen", 32'(pressCount > 8), 32'd1);
    checkOutput("longSeen", 32'(longCount > 0), 32'(LONG_ON));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
